// File: rtl/vga_text_pkg.sv
// Shared constants, control codes and FSM encoding for the VGA text writer.
package vga_text_pkg;

   localparam int         COLS_DEF  = 32;
   localparam int         ROWS_DEF  = 30;
   localparam logic [7:0] BLANK_DEF = 8'h20;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Video memory cell address: 32-column pitch regardless of COLS.
   function automatic logic [12:0] cell_addr(input logic [4:0] row, input logic [4:0] col);
      return {3'b000, row, col};
   endfunction

endpackage

// File: rtl/vga_cursor.sv
// Row/column counter with wrap; used both as the text cursor and as the clear sweep.
module vga_cursor
   import vga_text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_home,
   input  logic       i_advance,
   input  logic       i_newline,
   input  logic       i_cr,
   input  logic       i_back,
   output logic [4:0] o_row,
   output logic [4:0] o_col
);

   localparam logic [4:0] LAST_COL = 5'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   logic [4:0] r_row;
   logic [4:0] r_col;
   logic [4:0] w_row_inc;

   // Bottom row wraps to the top; there is no scrolling.
   assign w_row_inc = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= 5'd0;
         r_col <= 5'd0;
      end else if (i_home) begin
         r_row <= 5'd0;
         r_col <= 5'd0;
      end else if (i_advance) begin
         if (r_col == LAST_COL) begin
            r_col <= 5'd0;
            r_row <= w_row_inc;
         end else begin
            r_col <= r_col + 5'd1;
         end
      end else if (i_newline) begin
         r_col <= 5'd0;
         r_row <= w_row_inc;
      end else if (i_cr) begin
         r_col <= 5'd0;
      end else if (i_back && (r_col != 5'd0)) begin
         r_col <= r_col - 5'd1;
      end
   end

   assign o_row = r_row;
   assign o_col = r_col;

endmodule

// File: rtl/vga_text_writer.sv
// Character-stream to text-mode video memory writer with cursor control and screen clear.
module vga_text_writer
   import vga_text_pkg::*;
#(
   parameter int         COLS  = COLS_DEF,
   parameter int         ROWS  = ROWS_DEF,
   parameter logic [7:0] BLANK = BLANK_DEF
) (
   input  logic        clk_50mhz,
   input  logic        rst,
   input  logic [7:0]  ch_data,
   input  logic        ch_valid,
   output logic        ch_ready,
   output logic        Memwrite,
   output logic [12:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic [4:0]  cursor_row,
   output logic [4:0]  cursor_col,
   output logic        busy
);

   localparam logic [4:0] LAST_COL = 5'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   state_t      r_state;
   logic        r_memwrite;
   logic [12:0] r_mem_addr;
   logic [7:0]  r_mem_data;
   logic        r_clear_last;

   logic        w_accept;
   logic        w_printable;
   logic        w_is_lf;
   logic        w_is_cr;
   logic        w_is_ff;
   logic        w_bs_ok;
   logic        w_clr_step;
   logic        w_clr_at_end;
   logic        w_cur_home;
   logic [4:0]  w_cur_row;
   logic [4:0]  w_cur_col;
   logic [4:0]  w_clr_row;
   logic [4:0]  w_clr_col;

   assign w_accept    = ch_valid && (r_state == ST_IDLE);
   assign w_printable = (ch_data >= PRINT_LO) && (ch_data <= PRINT_HI);
   assign w_is_lf     = (ch_data == CH_LF);
   assign w_is_cr     = (ch_data == CH_CR);
   assign w_is_ff     = (ch_data == CH_FF);
   assign w_bs_ok     = (ch_data == CH_BS) && (w_cur_col != 5'd0);

   // The cycle after the last blank is issued homes the cursor and leaves CLEAR.
   assign w_clr_step   = (r_state == ST_CLEAR) && !r_clear_last;
   assign w_cur_home   = (r_state == ST_CLEAR) && r_clear_last;
   assign w_clr_at_end = (w_clr_row == LAST_ROW) && (w_clr_col == LAST_COL);

   vga_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk       (clk_50mhz),
      .rst_n     (rst),
      .i_home    (w_cur_home),
      .i_advance (w_accept && w_printable),
      .i_newline (w_accept && w_is_lf),
      .i_cr      (w_accept && w_is_cr),
      .i_back    (w_accept && w_bs_ok),
      .o_row     (w_cur_row),
      .o_col     (w_cur_col)
   );

   vga_cursor #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
      .clk       (clk_50mhz),
      .rst_n     (rst),
      .i_home    (w_accept && w_is_ff),
      .i_advance (w_clr_step),
      .i_newline (1'b0),
      .i_cr      (1'b0),
      .i_back    (1'b0),
      .o_row     (w_clr_row),
      .o_col     (w_clr_col)
   );

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_CLEAR;
         r_memwrite   <= 1'b0;
         r_mem_addr   <= 13'd0;
         r_mem_data   <= 8'd0;
         r_clear_last <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_clear_last) begin
                  r_memwrite   <= 1'b0;
                  r_clear_last <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  r_memwrite   <= 1'b1;
                  r_mem_addr   <= cell_addr(w_clr_row, w_clr_col);
                  r_mem_data   <= BLANK;
                  r_clear_last <= w_clr_at_end;
               end
            end
            ST_IDLE: begin
               r_memwrite <= 1'b0;
               if (ch_valid) begin
                  if (w_printable) begin
                     r_memwrite <= 1'b1;
                     r_mem_addr <= cell_addr(w_cur_row, w_cur_col);
                     r_mem_data <= ch_data;
                     r_state    <= ST_WRITE;
                  end else if (w_bs_ok) begin
                     r_memwrite <= 1'b1;
                     r_mem_addr <= cell_addr(w_cur_row, w_cur_col - 5'd1);
                     r_mem_data <= BLANK;
                     r_state    <= ST_WRITE;
                  end else if (w_is_ff) begin
                     r_state <= ST_CLEAR;
                  end
               end
            end
            ST_WRITE: begin
               r_memwrite <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_memwrite <= 1'b0;
               r_state    <= ST_CLEAR;
            end
         endcase
      end
   end

   assign ch_ready   = (r_state == ST_IDLE);
   assign busy       = (r_state == ST_CLEAR);
   assign Memwrite   = r_memwrite;
   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign cursor_row = w_cur_row;
   assign cursor_col = w_cur_col;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed self-checking bench for vga_text_writer: clear sweep, writes, control codes, reset abort.
module tb_vga_text_writer;

   logic        clk_50mhz = 1'b0;
   logic        rst       = 1'b0;
   logic [7:0]  ch_data   = 8'd0;
   logic        ch_valid  = 1'b0;
   logic        ch_ready;
   logic        Memwrite;
   logic [12:0] mem_addr;
   logic [7:0]  mem_data;
   logic [4:0]  cursor_row;
   logic [4:0]  cursor_col;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] b2b_code [5] = '{8'h0D, 8'h0A, 8'h0A, 8'h01, 8'h0A};
   logic [4:0] b2b_row  [5] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd3};

   always #10 clk_50mhz = ~clk_50mhz;

   vga_text_writer dut (
      .clk_50mhz  (clk_50mhz),
      .rst        (rst),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .ch_ready   (ch_ready),
      .Memwrite   (Memwrite),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Offers one code; returns the outputs seen the cycle after acceptance.
   task automatic send_char(input logic [7:0] c, output logic wrote, output logic [12:0] addr,
                            output logic [7:0] data, output logic rdy);
      int waited = 0;
      while (ch_ready !== 1'b1 && waited < 50) begin
         @(negedge clk_50mhz);
         waited++;
      end
      if (ch_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: ch_ready=%b required 1 before sending %02h", ch_ready, c);
      end
      ch_data  = c;
      ch_valid = 1'b1;
      @(negedge clk_50mhz);
      ch_valid = 1'b0;
      wrote = Memwrite;
      addr  = mem_addr;
      data  = mem_data;
      rdy   = ch_ready;
      if (wrote === 1'b1) @(negedge clk_50mhz);
      $display("char %02h: write=%b addr=%0d data=%02h cursor=(%0d,%0d)",
               c, wrote, addr, data, cursor_row, cursor_col);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk_50mhz);
      total++;
      if ({Memwrite, mem_addr, mem_data, cursor_row, cursor_col, ch_ready, busy} !==
          {1'b0, 13'd0, 8'd0, 5'd0, 5'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_state: we=%b addr=%0d data=%02h cur=(%0d,%0d) rdy=%b busy=%b required 0 0 00 (0,0) 0 1",
                  Memwrite, mem_addr, mem_data, cursor_row, cursor_col, ch_ready, busy);
      end
      $display("reset held: busy=%b ch_ready=%b", busy, ch_ready);
   endtask

   task automatic test_power_on_clear();
      int errs = 0;
      int fb_k = -1;
      logic fb_we = 1'b0;
      logic [12:0] fb_addr = '0;
      logic [7:0] fb_data = '0;
      ch_data  = 8'h58;
      ch_valid = 1'b1;
      rst      = 1'b1;
      for (int k = 0; k < 960; k++) begin
         @(negedge clk_50mhz);
         if (Memwrite !== 1'b1 || mem_addr !== 13'(k) || mem_data !== 8'h20 ||
             busy !== 1'b1 || ch_ready !== 1'b0) begin
            if (errs == 0) begin
               fb_k = k; fb_we = Memwrite; fb_addr = mem_addr; fb_data = mem_data;
            end
            errs++;
         end
      end
      ch_valid = 1'b0;
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL poweron_sweep: %0d bad cells, first cell %0d got we=%b addr=%0d data=%02h required we=1 addr=%0d data=20",
                  errs, fb_k, fb_we, fb_addr, fb_data, fb_k);
      end
      @(negedge clk_50mhz);
      total++;
      if ({Memwrite, ch_ready, busy, cursor_row, cursor_col} !== {1'b0, 1'b1, 1'b0, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL poweron_done: we=%b rdy=%b busy=%b cur=(%0d,%0d) required 0 1 0 (0,0)",
                  Memwrite, ch_ready, busy, cursor_row, cursor_col);
      end
      $display("power-on clear: 960 cells, %0d errors", errs);
   endtask

   task automatic test_single_char();
      logic w; logic [12:0] a; logic [7:0] d; logic r;
      send_char(8'h41, w, a, d, r);
      total++;
      if ({w, a, d, r} !== {1'b1, 13'd0, 8'h41, 1'b0}) begin
         bad++;
         $display("FAIL single_write: we=%b addr=%0d data=%02h rdy=%b required 1 0 41 0", w, a, d, r);
      end
      total++;
      if ({cursor_row, cursor_col} !== {5'd0, 5'd1}) begin
         bad++;
         $display("FAIL single_cursor: cur=(%0d,%0d) required (0,1)", cursor_row, cursor_col);
      end
      send_char(8'h0D, w, a, d, r);
      total++;
      if ({w, cursor_row, cursor_col} !== {1'b0, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL cr_home: we=%b cur=(%0d,%0d) required 0 (0,0)", w, cursor_row, cursor_col);
      end
   endtask

   task automatic test_row_wrap();
      logic w; logic [12:0] a; logic [7:0] d; logic r;
      int errs = 0;
      for (int i = 0; i < 33; i++) begin
         send_char(8'h30 + 8'(i), w, a, d, r);
         if (w !== 1'b1 || a !== 13'(i) || d !== 8'h30 + 8'(i)) errs++;
      end
      total++;
      if (errs != 0 || a !== 13'd32 || d !== 8'h50) begin
         bad++;
         $display("FAIL row_wrap_writes: %0d bad writes, last addr=%0d data=%02h required addr=32 data=50", errs, a, d);
      end
      total++;
      if ({cursor_row, cursor_col} !== {5'd1, 5'd1}) begin
         bad++;
         $display("FAIL row_wrap_cursor: cur=(%0d,%0d) required (1,1)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_bottom_wrap();
      logic w; logic [12:0] a; logic [7:0] d; logic r;
      int errs = 0;
      send_char(8'h0D, w, a, d, r);
      for (int i = 0; i < 28; i++) begin
         send_char(8'h0A, w, a, d, r);
         if (w !== 1'b0) errs++;
      end
      total++;
      if (errs != 0 || {cursor_row, cursor_col} !== {5'd29, 5'd0}) begin
         bad++;
         $display("FAIL lf_walk: %0d writes seen, cur=(%0d,%0d) required 0 writes (29,0)", errs, cursor_row, cursor_col);
      end
      for (int i = 0; i < 31; i++) send_char(8'h61, w, a, d, r);
      total++;
      if ({cursor_row, cursor_col} !== {5'd29, 5'd31}) begin
         bad++;
         $display("FAIL last_cell_cursor: cur=(%0d,%0d) required (29,31)", cursor_row, cursor_col);
      end
      send_char(8'h5A, w, a, d, r);
      total++;
      if ({w, a, d, cursor_row, cursor_col} !== {1'b1, 13'd959, 8'h5A, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL screen_wrap: we=%b addr=%0d data=%02h cur=(%0d,%0d) required 1 959 5A (0,0)",
                  w, a, d, cursor_row, cursor_col);
      end
      for (int i = 0; i < 29; i++) send_char(8'h0A, w, a, d, r);
      send_char(8'h0A, w, a, d, r);
      total++;
      if ({w, cursor_row, cursor_col} !== {1'b0, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL lf_wrap: we=%b cur=(%0d,%0d) required 0 (0,0)", w, cursor_row, cursor_col);
      end
   endtask

   task automatic test_backspace();
      logic w; logic [12:0] a; logic [7:0] d; logic r;
      for (int i = 0; i < 5; i++) send_char(8'h62, w, a, d, r);
      send_char(8'h08, w, a, d, r);
      total++;
      if ({w, a, d, cursor_row, cursor_col} !== {1'b1, 13'd4, 8'h20, 5'd0, 5'd4}) begin
         bad++;
         $display("FAIL bs_mid: we=%b addr=%0d data=%02h cur=(%0d,%0d) required 1 4 20 (0,4)",
                  w, a, d, cursor_row, cursor_col);
      end
      send_char(8'h0D, w, a, d, r);
      send_char(8'h08, w, a, d, r);
      total++;
      if ({w, cursor_row, cursor_col} !== {1'b0, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL bs_col0: we=%b cur=(%0d,%0d) required 0 (0,0)", w, cursor_row, cursor_col);
      end
   endtask

   task automatic test_ignored();
      logic w; logic [12:0] a; logic [7:0] d; logic r;
      logic [7:0] codes [4] = '{8'h01, 8'h7F, 8'h80, 8'h1B};
      int errs = 0;
      send_char(8'h63, w, a, d, r);
      for (int i = 0; i < 4; i++) begin
         send_char(codes[i], w, a, d, r);
         if (w !== 1'b0 || r !== 1'b1 || {cursor_row, cursor_col} !== {5'd0, 5'd1}) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL ignored_codes: %0d codes had effect, cur=(%0d,%0d) required 0 and (0,1)",
                  errs, cursor_row, cursor_col);
      end
   endtask

   task automatic test_back_to_back();
      int errs = 0;
      for (int i = 0; i < 5; i++) begin
         ch_data  = b2b_code[i];
         ch_valid = 1'b1;
         @(negedge clk_50mhz);
         if ({ch_ready, Memwrite, cursor_row, cursor_col} !== {1'b1, 1'b0, b2b_row[i], 5'd0}) errs++;
         $display("b2b %02h: rdy=%b cursor=(%0d,%0d)", b2b_code[i], ch_ready, cursor_row, cursor_col);
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL b2b_control: %0d bad cycles, last rdy=%b cur=(%0d,%0d) required rdy=1 cur=(3,0)",
                  errs, ch_ready, cursor_row, cursor_col);
      end
      ch_data = 8'h78;
      @(negedge clk_50mhz);
      total++;
      if ({Memwrite, ch_ready, mem_addr, mem_data} !== {1'b1, 1'b0, 13'd96, 8'h78}) begin
         bad++;
         $display("FAIL b2b_first: we=%b rdy=%b addr=%0d data=%02h required 1 0 96 78", Memwrite, ch_ready, mem_addr, mem_data);
      end
      ch_data = 8'h79;
      @(negedge clk_50mhz);
      total++;
      if ({Memwrite, ch_ready} !== {1'b0, 1'b1}) begin
         bad++;
         $display("FAIL b2b_gap: we=%b rdy=%b required 0 1", Memwrite, ch_ready);
      end
      @(negedge clk_50mhz);
      ch_valid = 1'b0;
      total++;
      if ({Memwrite, mem_addr, mem_data} !== {1'b1, 13'd97, 8'h79}) begin
         bad++;
         $display("FAIL b2b_second: we=%b addr=%0d data=%02h required 1 97 79", Memwrite, mem_addr, mem_data);
      end
      @(negedge clk_50mhz);
      $display("b2b printable pair done: cursor=(%0d,%0d)", cursor_row, cursor_col);
   endtask

   task automatic test_ff_reset();
      logic w; logic [12:0] a; logic [7:0] d; logic r;
      int errs = 0;
      send_char(8'h0C, w, a, d, r);
      total++;
      if ({w, r, busy} !== {1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL ff_enter: we=%b rdy=%b busy=%b required 0 0 1", w, r, busy);
      end
      for (int k = 0; k <= 400; k++) begin
         @(negedge clk_50mhz);
         if (Memwrite !== 1'b1 || mem_addr !== 13'(k) || mem_data !== 8'h20) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL ff_sweep: %0d bad cells in 0..400, at 400 addr=%0d required 400", errs, mem_addr);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({Memwrite, mem_addr, mem_data, cursor_row, cursor_col, ch_ready, busy} !==
          {1'b0, 13'd0, 8'd0, 5'd0, 5'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL abort_reset: we=%b addr=%0d data=%02h cur=(%0d,%0d) rdy=%b busy=%b required 0 0 00 (0,0) 0 1",
                  Memwrite, mem_addr, mem_data, cursor_row, cursor_col, ch_ready, busy);
      end
      $display("reset asserted mid-clear at cell 400");
      repeat (2) @(negedge clk_50mhz);
      rst  = 1'b1;
      errs = 0;
      for (int k = 0; k < 960; k++) begin
         @(negedge clk_50mhz);
         if (Memwrite !== 1'b1 || mem_addr !== 13'(k) || mem_data !== 8'h20) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL restart_sweep: %0d bad cells in 0..959 after release", errs);
      end
      @(negedge clk_50mhz);
      total++;
      if ({Memwrite, ch_ready, busy, cursor_row, cursor_col} !== {1'b0, 1'b1, 1'b0, 5'd0, 5'd0}) begin
         bad++;
         $display("FAIL restart_done: we=%b rdy=%b busy=%b cur=(%0d,%0d) required 0 1 0 (0,0)",
                  Memwrite, ch_ready, busy, cursor_row, cursor_col);
      end
      $display("restarted clear: 960 cells, %0d errors", errs);
   endtask

   initial begin
      test_reset();
      test_power_on_clear();
      test_single_char();
      test_row_wrap();
      test_bottom_wrap();
      test_backspace();
      test_ignored();
      test_back_to_back();
      test_ff_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_text_writer.md
VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning visible text rows.
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning the fill character for clear and backspace.
REQ-004 SHALL have port clk_50mhz, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; it is asynchronous and active-low.
REQ-006 SHALL have port ch_data, input, 8, the character code offered by the producer.
REQ-007 SHALL have port ch_valid, input, 1; high means ch_data is valid.
REQ-008 SHALL have port ch_ready, output, 1; high means the block accepts ch_data this cycle.
REQ-009 SHALL have port Memwrite, output, 1, the single-cycle video-memory write strobe.
REQ-010 SHALL have port mem_addr, output, 13, the cell address {3'b000, row[4:0], col[4:0]}.
REQ-011 SHALL have port mem_data, output, 8, the character written to the cell.
REQ-012 SHALL have port cursor_row, output, 5, the current cursor row (0..ROWS-1).
REQ-013 SHALL have port cursor_col, output, 5, the current cursor column (0..COLS-1).
REQ-014 SHALL have port busy, output, 1; high while a clear sequence runs.

Function
REQ-015 SHALL implement states CLEAR, IDLE and WRITE.
REQ-016 SHALL drive ch_ready high only in IDLE; a character is accepted when ch_valid and ch_ready are both high.
REQ-017 SHALL accept printable codes 8'h20..8'h7E, move to WRITE, and drive Memwrite=1 for exactly one cycle, the cycle after acceptance.
REQ-018 SHALL, during that printable write, set mem_addr to the pre-advance cursor and mem_data to the code.
REQ-019 SHALL advance the cursor after the printable write: col+1; at col=COLS-1, col 0 and row+1; at row=ROWS-1 with wrap, row 0 (no scrolling).
REQ-020 SHALL handle 8'h0A (LF) as col 0 and row+1 with the same row wrap, with no memory write.
REQ-021 SHALL handle 8'h0D (CR) as col 0, with no memory write.
REQ-022 SHALL handle 8'h08 (BS) when col>0 as col-1 plus one BLANK write at the new position; when col=0, no cursor change and no write.
REQ-023 SHALL handle 8'h0C (FF) by entering CLEAR.
REQ-024 SHALL ignore all other codes: accepted, no write, cursor unchanged, remain in IDLE.
REQ-025 SHALL complete every non-writing accepted code in one cycle, so ch_ready stays high for back-to-back input.
REQ-026 SHALL limit writing codes to a throughput of one per two cycles (ch_ready low during WRITE).
REQ-027 SHALL, in CLEAR, write BLANK to cells row 0..ROWS-1 × col 0..COLS-1, one per cycle, Memwrite continuously high, addresses ascending 0..959 by default.
REQ-028 SHALL, after the last CLEAR cell, set cursor to (0,0), return to IDLE and drop busy, with ch_ready high the next cycle.
REQ-029 SHALL hold ch_ready low and ignore ch_valid during CLEAR.
REQ-030 SHALL never produce a mem_addr outside the visible region (row<ROWS, col<COLS).
REQ-031 SHALL drive Memwrite, mem_addr and mem_data from registers, with no combinational path from ch_* inputs.

Reset
REQ-032 SHALL, while rst=0, hold Memwrite=0, mem_addr=0, mem_data=0, cursor (0,0), ch_ready=0 and busy=1, in state CLEAR with the clear counter at 0.
REQ-033 SHALL, on the first edge after rst rises, begin the CLEAR sequence (power-on screen wipe).
REQ-034 SHALL, when rst is asserted mid-operation (WRITE or CLEAR), abort immediately with no partial strobe and restart CLEAR from cell 0 after release.

Structure
REQ-035 SHALL place COLS/ROWS defaults, BLANK, control codes (LF, CR, BS, FF) and the state encoding in shared package vga_text_pkg.
REQ-036 SHALL implement the cursor as one sub-module, vga_cursor, a row/col counter with advance, newline, carriage-return, back and home inputs plus wrap logic, also reused as the CLEAR sweep counter.

Verification
REQ-037 SHALL cover: release reset -> 960 consecutive Memwrite cycles, mem_addr 0..959, mem_data 8'h20, then ch_ready=1 and cursor (0,0).
REQ-038 SHALL cover: in IDLE at (0,0), send 8'h41 -> next cycle Memwrite=1, mem_addr=0, mem_data=8'h41; cursor (0,1).
REQ-039 SHALL cover: 33 printable chars from (0,0) -> the 33rd write at mem_addr=32; final cursor (1,1).
REQ-040 SHALL cover: cursor (29,31), send 8'h5A -> write at mem_addr=959; cursor (0,0); and LF at row 29 -> cursor (0,0) with no write.
REQ-041 SHALL cover: BS at (0,5) -> write 8'h20 at mem_addr=4, cursor (0,4); BS at (0,0) -> no Memwrite, cursor unchanged.
REQ-042 SHALL cover: send FF, then assert rst at clear cell 400 -> outputs zero immediately; after release, clear restarts at mem_addr=0 and runs all 960 cells.
